// File: rtl/rr_burst_arbiter_if.sv
// Requester and output channel bundle for rr_burst_arbiter.
// master drives requests and out_ready_i; slave is the arbiter.
interface rr_burst_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [DATA_WIDTH-1:0]         out_data_o;
    logic                          out_last_o;
    logic [ID_WIDTH-1:0]           out_id_o;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic                          busy_o;

    modport master (
        output req_valid_i, req_data_i, req_last_i, out_ready_i,
        input  req_ready_o, out_data_o, out_last_o, out_id_o,
        input  out_valid_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, out_ready_i,
        output req_ready_o, out_data_o, out_last_o, out_id_o,
        output out_valid_o, busy_o
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: grant held until a last beat, with a
// 2-entry output FIFO that isolates out_ready_i from req_ready_o.
module rr_burst_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input logic              aclk,
    input logic              areset_n,
    rr_burst_arbiter_if.slave bus
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    logic [0:0]            r_state;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   r_rr_ptr;

    logic [DATA_WIDTH-1:0] r_mem_data [2];
    logic                  r_mem_last [2];
    logic [ID_WIDTH-1:0]   r_mem_id   [2];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic                  r_full;
    logic                  r_empty;

    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_any_req;
    logic [NUM_REQ-1:0]    w_req_ready;
    logic                  w_push;
    logic                  w_push_last;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_pop;
    logic [1:0]            w_wr_ptr_nxt;
    logic [1:0]            w_rd_ptr_nxt;
    logic                  w_full_nxt;
    logic                  w_empty_nxt;
    logic [ID_WIDTH-1:0]   w_ptr_after;

    function automatic logic [ID_WIDTH-1:0] wrap_add(
        input logic [ID_WIDTH-1:0] base,
        input int                  off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_WIDTH'(s);
    endfunction

    // Downward scan so the smallest offset from rr_ptr is the final winner.
    always_comb begin
        w_winner  = r_rr_ptr;
        w_any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid_i[wrap_add(r_rr_ptr, k)]) begin
                w_winner  = wrap_add(r_rr_ptr, k);
                w_any_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == S_LOCKED && !r_full) begin
            w_req_ready[r_grant] = 1'b1;
        end
    end

    assign w_push      = |(w_req_ready & bus.req_valid_i);
    assign w_push_last = bus.req_last_i[r_grant];
    assign w_push_data = bus.req_data_i[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_pop       = !r_empty && bus.out_ready_i;
    assign w_ptr_after = (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;

    assign w_wr_ptr_nxt = r_wr_ptr + {1'b0, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {1'b0, w_pop};
    assign w_full_nxt   = (w_wr_ptr_nxt[1] != w_rd_ptr_nxt[1]) &&
                          (w_wr_ptr_nxt[0] == w_rd_ptr_nxt[0]);
    assign w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_any_req) begin
                r_grant <= w_winner;
                r_state <= S_LOCKED;
            end
        end else if (w_push && w_push_last) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_ptr_after;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                r_mem_data[i] <= '0;
                r_mem_last[i] <= 1'b0;
                r_mem_id[i]   <= '0;
            end
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= w_empty_nxt;
            if (w_push) begin
                r_mem_data[r_wr_ptr[0]] <= w_push_data;
                r_mem_last[r_wr_ptr[0]] <= w_push_last;
                r_mem_id[r_wr_ptr[0]]   <= r_grant;
            end
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.busy_o      = (r_state == S_LOCKED);
    assign bus.out_valid_o = !r_empty;
    assign bus.out_data_o  = r_empty ? '0 : r_mem_data[r_rd_ptr[0]];
    assign bus.out_last_o  = r_empty ? 1'b0 : r_mem_last[r_rd_ptr[0]];
    assign bus.out_id_o    = r_empty ? '0 : r_mem_id[r_rd_ptr[0]];
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench for rr_burst_arbiter: a queue-based arbitration
// model predicts ready/busy and the beat stream checked by a monitor.
module tb_rr_burst_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    rr_burst_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    rr_burst_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .aclk    (aclk),
        .areset_n(areset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } src_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    src_t  srcq [N][$];
    beat_t sb[$];
    int    mon_log[$];
    bit    gate [N];
    int    vprob = 100;
    int    rprob = 100;

    bit m_locked = 1'b0;
    int m_grant  = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic void add_burst(int r, int len, logic [DW-1:0] base);
        for (int k = 0; k < len; k++) begin
            srcq[r].push_back('{last: (k == len - 1), data: base + DW'(k)});
        end
    endfunction

    function automatic void model_reset();
        m_locked = 1'b0;
        m_grant  = 0;
        m_ptr    = 0;
        m_cnt    = 0;
        sb.delete();
        for (int i = 0; i < N; i++) srcq[i].delete();
    endfunction

    function automatic bit pending();
        bit p;
        p = (sb.size() != 0) || m_locked;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic step(input bit rst = 1'b0);
        logic [N-1:0]    v;
        logic [N-1:0]    lst;
        logic [N*DW-1:0] dat;
        logic [N-1:0]    er;
        bit              push;
        bit              pop;
        src_t            b;
        @(negedge aclk);
        areset_n = !rst;
        for (int i = 0; i < N; i++) begin
            v[i] = (srcq[i].size() != 0) && gate[i] &&
                   ($urandom_range(99) < vprob);
            lst[i] = 1'b0;
            dat[i*DW +: DW] = $urandom;
            if (srcq[i].size() != 0) begin
                b = srcq[i][0];
                lst[i] = b.last;
                dat[i*DW +: DW] = b.data;
            end
        end
        bus.req_valid_i = v;
        bus.req_last_i  = lst;
        bus.req_data_i  = dat;
        bus.out_ready_i = ($urandom_range(99) < rprob);
        #1;
        er = '0;
        if (m_locked && m_cnt < 2) er[m_grant] = 1'b1;
        check("req_ready", 64'(bus.req_ready_o), 64'(er));
        check("busy", 64'(bus.busy_o), 64'(m_locked));
        check("out_valid", 64'(bus.out_valid_o), 64'(m_cnt > 0));
        if (m_cnt == 0) begin
            check("empty_data", 64'(bus.out_data_o), 64'(0));
            check("empty_last", 64'(bus.out_last_o), 64'(0));
        end
        push = ((er & v) != '0);
        pop  = (m_cnt > 0) && bus.out_ready_i;
        @(posedge aclk);
        if (rst) begin
            model_reset();
        end else begin
            if (pop) m_cnt--;
            if (push) begin
                b = srcq[m_grant].pop_front();
                sb.push_back('{id: IW'(m_grant), last: b.last, data: b.data});
                m_cnt++;
                if (b.last) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_grant + 1) % N;
                end
            end else if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_locked && v[(m_ptr + k) % N]) begin
                        m_locked = 1'b1;
                        m_grant  = (m_ptr + k) % N;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (pending() && t < 2000) begin
            step();
            t++;
        end
        n_cmp++;
        if (t >= 2000) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0",
                     sb.size());
        end
    endtask

    task automatic check_log(string name, int exp[$]);
        check({name, "_len"}, 64'(mon_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < mon_log.size(); i++) begin
            check(name, 64'(mon_log[i]), 64'(exp[i]));
        end
        mon_log.delete();
    endtask

    initial begin : monitor
        forever begin
            @(negedge aclk);
            #2;
            if (areset_n && bus.out_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(bus.out_data_o), 64'(0));
                end else begin
                    check("out_id", 64'(bus.out_id_o), 64'(sb[0].id));
                    check("out_last", 64'(bus.out_last_o), 64'(sb[0].last));
                    check("out_data", 64'(bus.out_data_o), 64'(sb[0].data));
                    if (bus.out_ready_i) begin
                        mon_log.push_back(int'(sb[0].id));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int t;
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.req_data_i  = '0;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < N; i++) gate[i] = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_ready", 64'(bus.req_ready_o), 64'(0));
        check("rst_valid", 64'(bus.out_valid_o), 64'(0));
        check("rst_data", 64'(bus.out_data_o), 64'(0));
        check("rst_last", 64'(bus.out_last_o), 64'(0));
        check("rst_id", 64'(bus.out_id_o), 64'(0));
        check("rst_busy", 64'(bus.busy_o), 64'(0));

        add_burst(2, 3, 32'hA0);
        drain();
        add_burst(3, 1, 32'hC3);
        add_burst(1, 1, 32'hC1);
        drain();
        check_log("single_wrap_ids", '{2, 2, 2, 3, 1});

        for (int r = 0; r < N; r++) add_burst(r, 1, 32'h100 + 32'(r));
        for (int r = 0; r < N; r++) add_burst(r, 1, 32'h200 + 32'(r));
        for (int r = 0; r < N; r++) add_burst(r, 1, 32'h300 + 32'(r));
        drain();
        check_log("rotation_ids",
                  '{2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1});

        rprob = 0;
        add_burst(0, 4, 32'hB0);
        repeat (8) step();
        rprob = 100;
        drain();
        check_log("backpressure_ids", '{0, 0, 0, 0});

        add_burst(1, 3, 32'hD0);
        add_burst(0, 2, 32'hE0);
        add_burst(3, 2, 32'hF0);
        step();
        step();
        gate[1] = 1'b0;
        repeat (5) step();
        gate[1] = 1'b1;
        drain();
        check_log("lock_hold_ids", '{1, 1, 1, 3, 3, 0, 0});

        vprob = 70;
        rprob = 60;
        for (int c = 0; c < 800; c++) begin
            for (int r = 0; r < N; r++) begin
                if (srcq[r].size() < 4 && $urandom_range(9) == 0) begin
                    add_burst(r, 1 + $urandom_range(3), $urandom);
                end
            end
            step();
        end
        vprob = 100;
        rprob = 100;
        drain();
        mon_log.delete();

        rprob = 0;
        add_burst(2, 5, 32'h5A0);
        t = 0;
        while (m_cnt < 2 && t < 20) begin
            step();
            t++;
        end
        check("fill_before_reset", 64'(bus.out_valid_o), 64'(1));
        step(1'b1);
        step();
        rprob = 100;
        add_burst(3, 1, 32'h73);
        add_burst(1, 1, 32'h71);
        drain();
        check_log("post_reset_ids", '{1, 3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
